// File: rtl/dadda_16_if.sv
// Multiplier port bundle: same signal names and widths as dadda_16's ports.
interface if_multiplier #(
  parameter int unsigned WIDTH = 16
) ();
  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] overflow;

  modport dut (
    input  clk,
    input  rst_n,
    input  in1,
    input  in2,
    output out,
    output overflow
  );

  modport drv (
    output clk,
    output rst_n,
    output in1,
    output in2,
    input  out,
    input  overflow
  );
endinterface

// File: rtl/dadda_16.sv
// Exact 16x16 unsigned multiplier: AND-array partial products, Dadda reduction
// tree (13, 9, 6, 4, 3, 2) built from half/full adders, a final carry-propagate
// adder, and one output register. {overflow, out} = in1 * in2 one cycle later.
module dadda_16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] overflow
);

  localparam int unsigned PW        = 2 * WIDTH;
  localparam int          NumStages = 6;

  if (WIDTH != 16) begin : g_width_check
    $error("dadda_16: only WIDTH = 16 is supported");
  end

  typedef logic [WIDTH-1:0][WIDTH-1:0] pp_t;

  // {carry, sum}
  function automatic logic [1:0] half_add(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

  // {carry, sum}
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  // Dadda height limit that stage st must reach.
  function automatic int stage_target(input int st);
    int t;
    case (st)
      0:       t = 13;
      1:       t = 9;
      2:       t = 6;
      3:       t = 4;
      4:       t = 3;
      default: t = 2;
    endcase
    return t;
  endfunction

  // Compress the partial-product columns to at most two bits per column and
  // return the two rows as {row1, row0}. The adder placement depends only on
  // constants, so the loops unroll into a fixed adder network.
  function automatic logic [2*PW-1:0] dadda_rows(input pp_t pp);
    logic [WIDTH-1:0] cur  [PW+1];
    logic [WIDTH-1:0] nxt  [PW+1];
    int               cnt  [PW+1];
    int               ncnt [PW+1];
    int               idx;
    int               d;
    int               h;
    logic [1:0]       sc;
    logic [PW-1:0]    row0;
    logic [PW-1:0]    row1;

    for (int k = 0; k <= PW; k++) begin
      cur[k]  = '0;
      nxt[k]  = '0;
      cnt[k]  = 0;
      ncnt[k] = 0;
    end

    // Drop every partial product bit into its weight column.
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        cur[i + j][cnt[i + j]] = pp[i][j];
        cnt[i + j] += 1;
      end
    end

    for (int st = 0; st < NumStages; st++) begin
      d = stage_target(st);
      for (int k = 0; k <= PW; k++) begin
        nxt[k]  = '0;
        ncnt[k] = 0;
      end
      // LSB first: carries out of column c already sit in nxt[c+1] when
      // column c+1 is processed, so they count towards its height.
      for (int c = 0; c < PW; c++) begin
        idx = 0;
        for (int r = 0; r < WIDTH; r++) begin
          h = cnt[c] - idx + ncnt[c];
          if (h > d) begin
            if (h == d + 1) begin
              sc = half_add(cur[c][idx], cur[c][idx + 1]);
              idx += 2;
            end else begin
              sc = full_add(cur[c][idx], cur[c][idx + 1], cur[c][idx + 2]);
              idx += 3;
            end
            nxt[c][ncnt[c]]         = sc[0];
            ncnt[c]                += 1;
            nxt[c + 1][ncnt[c + 1]] = sc[1];
            ncnt[c + 1]            += 1;
          end
        end
        // Bits not consumed by an adder pass straight through.
        for (int k = 0; k < WIDTH; k++) begin
          if (k >= idx && k < cnt[c]) begin
            nxt[c][ncnt[c]] = cur[c][k];
            ncnt[c]        += 1;
          end
        end
      end
      for (int k = 0; k <= PW; k++) begin
        cur[k] = nxt[k];
        cnt[k] = ncnt[k];
      end
    end

    for (int c = 0; c < PW; c++) begin
      row0[c] = (cnt[c] > 0) ? cur[c][0] : 1'b0;
      row1[c] = (cnt[c] > 1) ? cur[c][1] : 1'b0;
    end
    return {row1, row0};
  endfunction

  pp_t             w_pp;
  logic [2*PW-1:0] w_rows;
  logic [PW-1:0]   w_row0;
  logic [PW-1:0]   w_row1;
  logic [PW-1:0]   w_prod;
  logic [PW-1:0]   r_prod;

  // Partial products: w_pp[i][j] = in1[j] & in2[i], weight 2^(i+j).
  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    assign w_pp[i] = in1 & {WIDTH{in2[i]}};
  end

  // Reduce the partial-product matrix to two rows.
  always_comb begin
    w_rows = dadda_rows(w_pp);
  end

  assign w_row0 = w_rows[PW-1:0];
  assign w_row1 = w_rows[2*PW-1:PW];

  // The true product is below 2^32, so the adder's carry out of bit 31 is
  // always zero and a 32-bit sum loses nothing.
  assign w_prod = w_row0 + w_row1;

  // Output register; reset clears it immediately and discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod <= '0;
    end else begin
      r_prod <= w_prod;
    end
  end

  assign out      = r_prod[WIDTH-1:0];
  assign overflow = r_prod[PW-1:WIDTH];

endmodule

// File: tb/tb_dadda_16.sv
// Directed and random bench for dadda_16: reset behaviour, corner products,
// back-to-back issue, mid-operation reset, single-bit pairs and random pairs.
module tb_dadda_16;

  logic clk;
  int   errors;
  int   checks;

  if_multiplier #(.WIDTH(16)) mul_if ();

  assign mul_if.clk = clk;

  dadda_16 #(.WIDTH(16)) dut (
    .clk      (mul_if.clk),
    .rst_n    (mul_if.rst_n),
    .in1      (mul_if.in1),
    .in2      (mul_if.in2),
    .out      (mul_if.out),
    .overflow (mul_if.overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands after a falling edge, then sample 1 time unit past the
  // following rising edge.
  task automatic drive(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    mul_if.in1 = a;
    mul_if.in2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    mul_if.rst_n = 1'b1;
    mul_if.in1   = 16'h00FF;
    mul_if.in2   = 16'h0F0F;
    @(posedge clk);
    #2;
    mul_if.rst_n = 1'b0;
    #1;
    checks++;
    if (mul_if.out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_async_out: got %h expected 0000", mul_if.out);
    end
    checks++;
    if (mul_if.overflow !== 16'h0000) begin
      errors++;
      $display("FAIL reset_async_ovf: got %h expected 0000", mul_if.overflow);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mul_if.overflow, mul_if.out} !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold: got %h expected 00000000", {mul_if.overflow, mul_if.out});
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    mul_if.in1   = 16'd2;
    mul_if.in2   = 16'd4;
    mul_if.rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (mul_if.out !== 16'd8) begin
      errors++;
      $display("FAIL basic_out: got %h expected 0008", mul_if.out);
    end
    checks++;
    if (mul_if.overflow !== 16'h0000) begin
      errors++;
      $display("FAIL basic_ovf: got %h expected 0000", mul_if.overflow);
    end
  endtask

  task automatic test_corners();
    logic [15:0] a_tab   [4] = '{16'hFFFF, 16'h0100, 16'h0000, 16'hFFFF};
    logic [15:0] b_tab   [4] = '{16'hFFFF, 16'h0100, 16'hABCD, 16'h0001};
    logic [15:0] ovf_tab [4] = '{16'hFFFE, 16'h0001, 16'h0000, 16'h0000};
    logic [15:0] out_tab [4] = '{16'h0001, 16'h0000, 16'h0000, 16'hFFFF};
    for (int k = 0; k < 4; k++) begin
      drive(a_tab[k], b_tab[k]);
      checks++;
      if (mul_if.out !== out_tab[k]) begin
        errors++;
        $display("FAIL corner%0d_out: got %h expected %h", k, mul_if.out, out_tab[k]);
      end
      checks++;
      if (mul_if.overflow !== ovf_tab[k]) begin
        errors++;
        $display("FAIL corner%0d_ovf: got %h expected %h", k, mul_if.overflow, ovf_tab[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(16'd3, 16'd5);
    checks++;
    if ({mul_if.overflow, mul_if.out} !== 32'd15) begin
      errors++;
      $display("FAIL b2b_first: got %h expected 0000000f", {mul_if.overflow, mul_if.out});
    end
    // New operands between edges must not disturb the registered result.
    mul_if.in1 = 16'h1234;
    mul_if.in2 = 16'h5678;
    #2;
    checks++;
    if ({mul_if.overflow, mul_if.out} !== 32'd15) begin
      errors++;
      $display("FAIL b2b_stable: got %h expected 0000000f", {mul_if.overflow, mul_if.out});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({mul_if.overflow, mul_if.out} !== 32'h0626_0060) begin
      errors++;
      $display("FAIL b2b_second: got %h expected 06260060", {mul_if.overflow, mul_if.out});
    end
  endtask

  task automatic test_reset_midflight();
    drive(16'hFFFF, 16'hFFFF);
    checks++;
    if ({mul_if.overflow, mul_if.out} !== 32'hFFFE_0001) begin
      errors++;
      $display("FAIL mid_pre: got %h expected fffe0001", {mul_if.overflow, mul_if.out});
    end
    mul_if.in1 = 16'd7;
    mul_if.in2 = 16'd9;
    #2;
    mul_if.rst_n = 1'b0;
    #1;
    checks++;
    if ({mul_if.overflow, mul_if.out} !== 32'h0) begin
      errors++;
      $display("FAIL mid_async: got %h expected 00000000", {mul_if.overflow, mul_if.out});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({mul_if.overflow, mul_if.out} !== 32'h0) begin
      errors++;
      $display("FAIL mid_hold: got %h expected 00000000", {mul_if.overflow, mul_if.out});
    end
    @(negedge clk);
    mul_if.rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({mul_if.overflow, mul_if.out} !== 32'd63) begin
      errors++;
      $display("FAIL mid_release: got %h expected 0000003f", {mul_if.overflow, mul_if.out});
    end
  endtask

  task automatic test_single_bits();
    logic [31:0] one;
    logic [31:0] exp;
    logic [15:0] a;
    logic [15:0] b;
    one = 32'd1;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a   = 16'(one << i);
        b   = 16'(one << j);
        exp = one << (i + j);
        drive(a, b);
        checks++;
        if ({mul_if.overflow, mul_if.out} !== exp) begin
          errors++;
          $display("FAIL bit_%0d_%0d: got %h expected %h", i, j,
                   {mul_if.overflow, mul_if.out}, exp);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
    for (int n = 0; n < 10000; n++) begin
      a   = 16'($urandom_range(0, 65535));
      b   = 16'($urandom_range(0, 65535));
      exp = {16'h0000, a} * {16'h0000, b};
      drive(a, b);
      checks++;
      if ({mul_if.overflow, mul_if.out} !== exp) begin
        errors++;
        $display("FAIL random_%0d: %h*%h got %h expected %h", n, a, b,
                 {mul_if.overflow, mul_if.out}, exp);
      end
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    mul_if.rst_n  = 1'b1;
    mul_if.in1    = '0;
    mul_if.in2    = '0;
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_reset_midflight();
    test_single_bits();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
